moving_sum_deconv: RTL

Inverse of the moving-window sum stage. It takes the full-precision windowed sum stream produced by a WINDOW-tap moving-sum/average path, before the low bits are dropped, and recovers the original sample stream exactly. The recurrence is x[n] = s[n] − s[n−1] + x[n−WINDOW]. It sits on the receive/analysis side of the filter chain and is used for loopback checking and for undoing smoothing on stored sum traces.

---
 rtl/moving_sum_deconv_if.sv | 18 +
 rtl/moving_sum_deconv.sv | 87 ++++++++
 2 files changed

// File: rtl/moving_sum_deconv_if.sv
// Stream bundle for moving_sum_deconv: running window sum in, recovered sample plus status out.
// Instantiate with the same WIDTH/WINDOW as the block it connects to.
interface moving_sum_deconv_if #(
  parameter int WIDTH  = 32,
  parameter int WINDOW = 4
);
  localparam int SUM_WIDTH = WIDTH + $clog2(WINDOW);

  logic                        ivalid;
  logic signed [SUM_WIDTH-1:0] isum;
  logic                        ovalid;
  logic signed [WIDTH-1:0]     odata;
  logic                        warm;
  logic                        err;

  modport master (output ivalid, isum, input ovalid, odata, warm, err);
  modport slave  (input ivalid, isum, output ovalid, odata, warm, err);
endinterface

// File: rtl/moving_sum_deconv.sv
// Recovers x[n] = s[n] - s[n-1] + x[n-WINDOW] from a full-precision moving-window sum stream.
// Latency 1 cycle, one sample per clock; no backpressure, ivalid gaps simply hold state.
// Define MOVING_SUM_DECONV_CHECK_EN to build the sticky overflow flag on err (tied 0 otherwise).
module moving_sum_deconv #(
  parameter int WIDTH  = 32,
  parameter int WINDOW = 4
) (
  input logic                clock,
  input logic                reset,
  moving_sum_deconv_if.slave bus
);
  localparam int SUM_WIDTH = WIDTH + $clog2(WINDOW);
  localparam int FILL_W    = $clog2(WINDOW + 1);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(WINDOW - 1);
  localparam logic [FILL_W-1:0] FILL_MAX  = FILL_W'(WINDOW);
  localparam logic [FILL_W-1:0] FILL_ONE  = FILL_W'(1);

  generate
    if (WINDOW < 2 || (WINDOW & (WINDOW - 1)) != 0) begin : g_bad_window
      $error("moving_sum_deconv: WINDOW must be a power of two and at least 2");
    end
  endgenerate

  logic signed [SUM_WIDTH-1:0] sum_prev;
  logic signed [WIDTH-1:0]     hist [WINDOW];
  logic [FILL_W-1:0]           fill;
  logic                        ovalid_q;
  logic                        warm_q;
  logic signed [WIDTH-1:0]     odata_q;
  logic signed [SUM_WIDTH:0]   d;
  logic signed [SUM_WIDTH:0]   x;

  // hist[WINDOW-1] is the oldest sample, the one leaving the window.
  always_comb begin
    d = {bus.isum[SUM_WIDTH-1], bus.isum} - {sum_prev[SUM_WIDTH-1], sum_prev};
    x = d + {{(SUM_WIDTH + 1 - WIDTH){hist[WINDOW-1][WIDTH-1]}}, hist[WINDOW-1]};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sum_prev <= '0;
      for (int i = 0; i < WINDOW; i++) hist[i] <= '0;
      fill     <= '0;
      ovalid_q <= 1'b0;
      odata_q  <= '0;
      warm_q   <= 1'b0;
    end else begin
      ovalid_q <= bus.ivalid;
      if (bus.ivalid) begin
        sum_prev <= bus.isum;
        odata_q  <= x[WIDTH-1:0];
        hist[0]  <= x[WIDTH-1:0];
        for (int i = 1; i < WINDOW; i++) hist[i] <= hist[i-1];
        if (fill != FILL_MAX) fill <= fill + FILL_ONE;
        if (fill == FILL_LAST) warm_q <= 1'b1;
      end
    end
  end

  assign bus.ovalid = ovalid_q;
  assign bus.odata  = odata_q;
  assign bus.warm   = warm_q;

`ifdef MOVING_SUM_DECONV_CHECK_EN
  logic x_ovf;
  logic err_q;

  // x fits in WIDTH signed bits only if every bit above the sign bit copies it.
  always_comb begin
    x_ovf = (x[SUM_WIDTH:WIDTH-1] != '0) && (x[SUM_WIDTH:WIDTH-1] != '1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (bus.ivalid && x_ovf) begin
      err_q <= 1'b1;
    end
  end

  assign bus.err = err_q;
`else
  logic unused_x_hi;
  assign unused_x_hi = ^x[SUM_WIDTH:WIDTH];
  assign bus.err     = 1'b0;
`endif
endmodule
